// File: rtl/load_store_unit_if.sv
// Core-side request/response and word-memory signals of the load/store unit.
interface load_store_unit_if;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        stall;
  logic [1:0]  err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_flag_write;
  logic        mem_flag_read;

  modport slave (
    input  req, op, addr, store_data, mem_read_data,
    output load_data, done, stall, err,
           mem_address, mem_write_data, mem_flag_write, mem_flag_read
  );

  modport master (
    output req, op, addr, store_data, mem_read_data,
    input  load_data, done, stall, err,
           mem_address, mem_write_data, mem_flag_write, mem_flag_read
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store to a word memory; SB/SH via read-modify-write.
// done after 1 (error), 2 (LW/LB/LH/SW) or 3 (SB/SH) cycles; stalls the core meanwhile.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [3:0] OP_LB = 4'd0, OP_LH = 4'd1, OP_LW = 4'd2, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;
  localparam logic [31:0] MEM_WORDS_W = MEM_WORDS;

  typedef enum logic [2:0] {IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR, DONE} state_t;

  // Only the fields still needed after acceptance are kept.
  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  lane;
    logic [15:0] sd;
  } acc_t;

  state_t      state, next_state;
  acc_t        acc;
  logic        accept, is_load, is_store, is_half, is_word;
  logic [1:0]  chk_err, err_q, err_nxt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_q, load_nxt, wdata_q, wdata_nxt, maddr_q, maddr_nxt, merged;
  logic        done_q, done_nxt, rd_q, rd_nxt, wr_q, wr_nxt;

  assign accept = (state == IDLE) && bus.req;

  always_comb begin
    is_load  = bus.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store = bus.op inside {OP_SB, OP_SH, OP_SW};
    is_half  = bus.op inside {OP_LH, OP_LHU, OP_SH};
    is_word  = bus.op inside {OP_LW, OP_SW};
    chk_err  = 2'b00;
    if (!(is_load || is_store))
      chk_err = 2'b11;
    else if ((is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00)))
      chk_err = 2'b01;
    else if ({2'b00, bus.addr[31:2]} >= MEM_WORDS_W)
      chk_err = 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      load_q  <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
      err_q   <= 2'b00;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state   <= next_state;
      if (accept)
        acc <= '{op: bus.op, lane: bus.addr[1:0], sd: bus.store_data[15:0]};
      load_q  <= load_nxt;
      wdata_q <= wdata_nxt;
      maddr_q <= maddr_nxt;
      err_q   <= err_nxt;
      done_q  <= done_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.req) begin
        if (chk_err != 2'b00)     next_state = DONE;
        else if (is_load)         next_state = LD_RD;
        else if (bus.op == OP_SW) next_state = ST_WR;
        else                      next_state = RMW_RD;
      end
      LD_RD:   next_state = DONE;
      ST_WR:   next_state = DONE;
      RMW_RD:  next_state = RMW_WR;
      RMW_WR:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output registers are loaded from next-cycle values so every mem_* pin is a flop.
  always_comb begin
    rd_byte   = bus.mem_read_data[{acc.lane, 3'b000} +: 8];
    rd_half   = bus.mem_read_data[{acc.lane[1], 4'b0000} +: 16];
    merged    = bus.mem_read_data;
    if (acc.op == OP_SB)
      merged[{acc.lane, 3'b000} +: 8] = acc.sd[7:0];
    else
      merged[{acc.lane[1], 4'b0000} +: 16] = acc.sd;

    load_nxt  = load_q;
    if (state == LD_RD) begin
      case (acc.op)
        OP_LB:   load_nxt = {{24{rd_byte[7]}}, rd_byte};
        OP_LBU:  load_nxt = {24'h0, rd_byte};
        OP_LH:   load_nxt = {{16{rd_half[15]}}, rd_half};
        OP_LHU:  load_nxt = {16'h0, rd_half};
        default: load_nxt = bus.mem_read_data;
      endcase
    end

    wdata_nxt = wdata_q;
    if (accept && next_state == ST_WR) wdata_nxt = bus.store_data;
    else if (state == RMW_RD)          wdata_nxt = merged;

    maddr_nxt = accept ? {2'b00, bus.addr[31:2]} : maddr_q;
    err_nxt   = accept ? chk_err : err_q;
    done_nxt  = (next_state == DONE);
    rd_nxt    = (next_state == LD_RD) || (next_state == RMW_RD);
    wr_nxt    = (next_state == ST_WR) || (next_state == RMW_WR);
  end

  assign bus.load_data      = load_q;
  assign bus.done           = done_q;
  assign bus.stall          = bus.req & ~done_q;
  assign bus.err            = err_q;
  assign bus.mem_address    = maddr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_flag_read  = rd_q;
  assign bus.mem_flag_write = wr_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/control path and the word-wide data memory.
- Turns byte, halfword and word loads/stores (LB, LBU, LH, LHU, LW, SB, SH, SW) into word-indexed memory accesses.
- Sub-word stores use a read-modify-write sequence.
- Stalls the processor until each access completes, and flags misaligned, out-of-range and illegal requests without touching memory.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the data memory; word index must be < MEM_WORDS.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request; held high by the core until done.
- op  input  4  access type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; all other codes illegal.
- addr  input  32  byte address from the ALU.
- store_data  input  32  store operand; the low byte or halfword is used for SB/SH.
- load_data  output  32  extended load result, registered.
- done  output  1  one-cycle completion pulse.
- stall  output  1  combinational: req & ~done.
- err  output  2  registered status, valid with done: 00 ok, 01 misaligned, 10 out-of-range, 11 illegal op.
- mem_address  output  32  word index to the memory: {2'b00, addr[31:2]}, registered.
- mem_write_data  output  32  word to write, registered.
- mem_read_data  input  32  read data from the memory, valid after the falling edge of a read cycle.
- mem_flag_write  output  1  memory write enable.
- mem_flag_read  output  1  memory read enable.

Behaviour:
- Reset: state IDLE, load_data 0, done 0, err 00, mem_address 0, mem_write_data 0, both mem flags 0.
- Memory interface: memory samples on the falling clock edge. All mem_* outputs come from registers, so they are stable across that edge.
- Byte lanes: little-endian; byte k = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- States: IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR, DONE.
- Acceptance: only in IDLE with req=1. Latch op, addr and store_data on that edge.
- Validity checks at acceptance, priority illegal > misaligned > range:
  - misaligned = (H ops & addr[0]) | (W ops & addr[1:0]!=0)
  - out-of-range = addr[31:2] >= MEM_WORDS
  - Any error: go to DONE with err set; no mem flag is ever asserted.
- IDLE -> LD_RD for LB/LBU/LH/LHU/LW.
  - LD_RD asserts mem_flag_read.
  - On the next edge: select the byte/halfword/word, sign-extend (LB, LH) or zero-extend (LBU, LHU), register into load_data, go to DONE.
- IDLE -> ST_WR for SW.
  - ST_WR asserts mem_flag_write with mem_write_data = store_data, then goes to DONE.
- IDLE -> RMW_RD for SB/SH.
  - RMW_RD asserts mem_flag_read.
  - On the next edge: capture mem_read_data, merge in the target lane(s) of store_data, register the result into mem_write_data, go to RMW_WR.
  - RMW_WR asserts mem_flag_write, then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. A req seen in DONE is not accepted until IDLE.
- Latency from the accepting edge to done high: error 1 cycle, LW/LB/LH/SW 2 cycles, SB/SH 3 cycles.
- load_data changes only on successful loads; it holds across stores and errors.
- Never assert mem_flag_read and mem_flag_write in the same cycle.
- A change of op/addr/store_data after acceptance has no effect on the access in flight.
- If req drops mid-access, the access completes anyway and done still pulses.
- Reset mid-operation: return to IDLE and drop flags on that edge.
  - A RMW_RD interrupted by reset leaves memory unmodified.
  - A write whose falling edge already occurred stands.

Test Plan:
- Reset, then idle 3 cycles -> load_data=0, done=0, err=00, both mem flags 0, stall=0.
- SW addr=0x8, store_data=0xDEADBEEF, then LW addr=0x8 -> mem_address=2; write flag high for exactly 1 cycle; LW done 2 cycles after acceptance with load_data=0xDEADBEEF.
- With word 2 = 0xDEADBEEF, run LB addr=0xB, LBU addr=0xB, LH addr=0xA, LHU addr=0xA -> load_data = 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD respectively.
- SB addr=0x9, store_data=0x12345677, then LW addr=0x8 -> word reads 0xDEAD77EF; RMW read then write cycles observed; done 3 cycles after acceptance.
- LH addr=0x3, SW addr=0x6, LW addr=4*MEM_WORDS, op=3 -> err 01, 01, 10, 11 respectively; done 1 cycle after acceptance; no mem flag asserted; load_data unchanged.
- Start SH addr=0x4, assert reset during RMW_RD -> state IDLE, flags 0; word 1 unchanged on readback; next LW accepted normally.
